fifo_unpack: RTL



---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_unpack_oreg.sv | 40 ++++
 rtl/fifo_unpack.sv | 105 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side blocks: default widths,
// hold-register FSM states and the log2 helper used to size slice indices.
package fifo_pkg;

  localparam int unsigned IW_DEF = 32;
  localparam int unsigned OW_DEF = 16;

  typedef enum logic {
    H_EMPTY = 1'b0,
    H_FULL  = 1'b1
  } hold_state_t;

  // ceil(log2(n)), never less than 1 so a 2-way index still gets one bit
  function automatic int unsigned clogb2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_unpack_oreg.sv
// Registered valid/ready output stage: takes a new slice whenever the stage
// is empty or its current slice is being accepted; flush empties it.
module fifo_unpack_oreg #(
  parameter int unsigned OW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          load,
  input  logic [OW-1:0] din,
  input  logic          din_last,
  input  logic          rdy,
  output logic          adv,
  output logic [OW-1:0] dat,
  output logic          last,
  output logic          vld
);

  assign adv = !vld || rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat  <= '0;
      last <= 1'b0;
      vld  <= 1'b0;
    end else if (flush) begin
      last <= 1'b0;
      vld  <= 1'b0;
    end else if (adv) begin
      if (load) begin
        dat  <= din;
        last <= din_last;
        vld  <= 1'b1;
      end else begin
        vld  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fifo_unpack.sv
// Pops wide words from a show-ahead FIFO and serialises each into RATIO
// narrow slices on a valid/ready stream, refilling without bubbles.
module fifo_unpack
  import fifo_pkg::*;
#(
  parameter int unsigned IW        = IW_DEF,
  parameter int unsigned OW        = OW_DEF,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] fifo_out,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  input  logic          flush,
  output logic [OW-1:0] out_dat,
  output logic          out_last,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic          busy
);

  localparam int unsigned RATIO = IW / OW;
  localparam int unsigned SEL_W = clogb2(RATIO);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(RATIO - 1);

  hold_state_t      state, state_d;
  logic [IW-1:0]    hreg;
  logic [SEL_W-1:0] sel;
  logic             hold_vld;
  logic             adv;
  logic             last_move;
  logic             rd_en;
  int unsigned      slice_idx;
  logic [OW-1:0]    slice;

  assign hold_vld = (state == H_FULL);

  always_comb begin
    slice_idx = MSB_FIRST ? (RATIO - 1 - 32'(sel)) : 32'(sel);
    slice     = hreg[slice_idx*OW +: OW];
  end

  // The last slice moving into the output stage frees the hold register in
  // the same cycle, so the next word may be popped right then.
  always_comb begin
    state_d   = state;
    rd_en     = 1'b0;
    last_move = adv && hold_vld && (sel == SEL_LAST);
    if (!rst && !flush) begin
      unique case (state)
        H_EMPTY: rd_en = !fifo_empty;
        H_FULL:  rd_en = last_move && !fifo_empty;
        default: rd_en = 1'b0;
      endcase
    end
    if (flush) begin
      state_d = H_EMPTY;
    end else begin
      unique case (state)
        H_EMPTY: if (rd_en) state_d = H_FULL;
        H_FULL:  if (last_move && !rd_en) state_d = H_EMPTY;
        default: state_d = H_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= H_EMPTY;
      hreg  <= '0;
      sel   <= '0;
    end else begin
      state <= state_d;
      if (flush) begin
        sel <= '0;
      end else if (rd_en) begin
        hreg <= fifo_out;
        sel  <= '0;
      end else if (adv && hold_vld) begin
        sel <= (sel == SEL_LAST) ? '0 : sel + SEL_W'(1);
      end
    end
  end

  fifo_unpack_oreg #(
    .OW (OW)
  ) u_oreg (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .load     (hold_vld),
    .din      (slice),
    .din_last (sel == SEL_LAST),
    .rdy      (out_rdy),
    .adv      (adv),
    .dat      (out_dat),
    .last     (out_last),
    .vld      (out_vld)
  );

  assign fifo_rd_en = rd_en;
  assign busy       = hold_vld || out_vld;

endmodule
